// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit beside the execute-stage ALU.
// Radix-2 shift/add multiply, restoring shift/subtract divide, one bit per cycle,
// with the 2*WIDTH result held in HI/LO.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   start, op, operand1/2     request (op: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV)
//   readHiLo                  execute stage reads HI/LO this cycle
//   writeHi, writeLo, writeData  move-to HI/LO, honoured only when idle
//   flush                     abort any in-flight operation
//   busy, done, stall         status toward the pipeline
//   hi, lo                    result registers
//
// Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies leave RUN as
// soon as the remaining multiplier bits are all zero.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             readHiLo,
    input  logic             writeHi,
    input  logic             writeLo,
    input  logic [WIDTH-1:0] writeData,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      counter_q, counter_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;      // mul: {partial, multiplier}; div: {rem, dividend/quotient}
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;    // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // operand magnitudes for a new request
    logic               req_sa, req_sb;
    logic [WIDTH-1:0]   mag1, mag2;

    // one iteration of each datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_tmp, div_diff;
    logic               div_borrow;
    logic [2*WIDTH-1:0] div_next, iter_next;

    // sign fix-up
    logic [2*WIDTH-1:0] prod_mag;
    logic [WIDTH-1:0]   quo_mag, rem_mag;

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0]   low_mask;
    logic               mul_rest_zero;
`endif

    always_comb begin
        req_sa = op[0] & operand1[WIDTH-1];
        req_sb = op[0] & operand2[WIDTH-1];
        mag1   = req_sa ? -operand1 : operand1;
        mag2   = req_sb ? -operand2 : operand2;

        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        div_tmp    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff   = div_tmp - {1'b0, dvsr_q};
        div_borrow = div_tmp < {1'b0, dvsr_q};
        div_next   = {(div_borrow ? div_tmp[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], ~div_borrow};
        iter_next  = is_div_q ? div_next : mul_next;

`ifdef MULDIV_EARLY_OUT_EN
        // after the iteration at count c, the low c bits still hold unused multiplier bits
        low_mask      = ~({WIDTH{1'b1}} << counter_q);
        mul_rest_zero = (mul_next[WIDTH-1:0] & low_mask) == '0;
        // an early exit leaves counter_q at the number of shifts still owed
        prod_mag      = acc_q >> counter_q;
`else
        prod_mag      = acc_q;
`endif
        quo_mag = acc_q[WIDTH-1:0];
        rem_mag = acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        acc_d     = acc_q;
        dvsr_d    = dvsr_q;
        is_div_d  = is_div_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = RUN;
                        counter_d = CW'(WIDTH - 1);
                        is_div_d  = op[1];
                        sign_a_d  = req_sa;
                        sign_b_d  = req_sb;
                        acc_d     = {{WIDTH{1'b0}}, (op[1] ? mag1 : mag2)};
                        dvsr_d    = op[1] ? mag2 : mag1;
                    end else begin
                        if (writeHi) hi_d = writeData;
                        if (writeLo) lo_d = writeData;
                    end
                end
                RUN: begin
                    acc_d = iter_next;
                    if (counter_q == '0) begin
                        state_d = FIX;
`ifdef MULDIV_EARLY_OUT_EN
                    end else if (!is_div_q && mul_rest_zero) begin
                        state_d = FIX;
`endif
                    end else begin
                        counter_d = counter_q - 1'b1;
                    end
                end
                FIX: begin
                    state_d   = IDLE;
                    counter_d = '0;
                    done_d    = 1'b1;
                    if (is_div_q) begin
                        // with a zero divisor no subtract ever borrows, so the remainder
                        // ends up as the dividend magnitude and signs back to the original
                        hi_d = sign_a_q ? -rem_mag : rem_mag;
                        lo_d = (dvsr_q == '0) ? '1 :
                               ((sign_a_q ^ sign_b_q) ? -quo_mag : quo_mag);
                    end else begin
                        {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            acc_q     <= '0;
            dvsr_q    <= '0;
            is_div_q  <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            acc_q     <= acc_d;
            dvsr_q    <= dvsr_d;
            is_div_q  <= is_div_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = busy_q & (start | readHiLo | writeHi | writeLo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset, start, readHiLo, writeHi, writeLo, flush;
    logic [1:0]   op;
    logic [W-1:0] operand1, operand2, writeData;
    logic         busy, done, stall;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand1(operand1), .operand2(operand2), .readHiLo(readHiLo),
        .writeHi(writeHi), .writeLo(writeLo), .writeData(writeData),
        .flush(flush), .busy(busy), .done(done), .stall(stall),
        .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // called in cycle 1 of an operation; returns in the done cycle (or after the bound)
    task automatic wait_done(output int lat, output int busy_bad);
        lat = 1;
        busy_bad = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_bad++;
            tick();
            lat++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
        chk("busy_in_done_cycle", {63'd0, busy}, 64'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_bad);
        op = o; operand1 = a; operand2 = b; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, busy_bad);
    endtask

    initial begin
        int lat, bb, bad, seen;
        logic exp_s;

        vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{2'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'd2, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[4]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{2'd0, 32'd5,        32'd3,        32'd0,        32'd15};
        vecs[6]  = '{2'd2, 32'd10,       32'd3,        32'd1,        32'd3};
        vecs[7]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[9]  = '{2'd0, 32'h12345678, 32'd0,        32'd0,        32'd0};
        vecs[10] = '{2'd3, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF};
        vecs[11] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};

        reset = 1'b1; start = 0; readHiLo = 0; writeHi = 0; writeLo = 0; flush = 0;
        op = 0; operand1 = 0; operand2 = 0; writeData = 0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bb);
            chk($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
            chk($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
`ifdef MULDIV_EARLY_OUT_EN
            if (vecs[i].op[1]) chk($sformatf("vec%0d_lat", i), lat, 64'd34);
            else chk($sformatf("vec%0d_lat_le", i), {63'd0, lat <= 34}, 64'd1);
`else
            chk($sformatf("vec%0d_lat", i), lat, 64'd34);
            chk($sformatf("vec%0d_busy_1_33", i), bb, 64'd0);
`endif
            tick();
            chk($sformatf("vec%0d_done_pulse", i), {63'd0, done}, 64'd0);
        end

        // stall window, plus start/writeLo ignored while busy
        op = 2'd2; operand1 = 32'd10; operand2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        bad = 0;
        for (int c = 1; c <= 34; c++) begin
            start = (c == 3); writeLo = (c == 3); writeData = 32'hDEAD;
            op = 2'd0; operand1 = 32'd9; operand2 = 32'd9;
            readHiLo = (c >= 5);
            #1;
            if (c < 34) begin
                exp_s = (c == 3) || (c >= 5);
                if (stall !== exp_s) bad++;
                if (done !== 1'b0) bad++;
                tick();
            end else begin
                chk("stall_c34", {63'd0, stall}, 64'd0);
                chk("done_c34", {63'd0, done}, 64'd1);
                chk("stall_hi", {32'd0, hi}, 64'd1);
                chk("stall_lo", {32'd0, lo}, 64'd3);
            end
        end
        chk("stall_window_bad", bad, 64'd0);
        readHiLo = 1'b0;

        // back-to-back start in the done cycle
        run_op(2'd0, 32'd6, 32'd7, lat, bb);
        op = 2'd1; operand1 = 32'hFFFFFFFD; operand2 = 32'd7; start = 1'b1;
        #1;
        chk("b2b_stall", {63'd0, stall}, 64'd0);
        tick();
        start = 1'b0;
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(lat, bb);
        chk("b2b_lo", {32'd0, lo}, {32'd0, 32'hFFFFFFEB});

        // flush mid-operation; hi/lo = FFFFFFFF/FFFFFFEB beforehand
        op = 2'd0; operand1 = 32'd7; operand2 = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_hi", {32'd0, hi}, {32'd0, 32'hFFFFFFFF});
        chk("flush_lo", {32'd0, lo}, {32'd0, 32'hFFFFFFEB});
        seen = 0;
        tick();
        writeLo = 1'b1; writeData = 32'h1234;
        tick();
        writeLo = 1'b0;
        chk("write_lo", {32'd0, lo}, 64'h1234);
        chk("write_lo_hi_kept", {32'd0, hi}, {32'd0, 32'hFFFFFFFF});
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        chk("flush_no_done", seen, 64'd0);

        // start and writeHi together: start wins
        op = 2'd0; operand1 = 32'd2; operand2 = 32'd3; start = 1'b1;
        writeHi = 1'b1; writeData = 32'hFFFF;
        tick();
        start = 1'b0; writeHi = 1'b0;
        wait_done(lat, bb);
        chk("start_wins_hi", {32'd0, hi}, 64'd0);
        chk("start_wins_lo", {32'd0, lo}, 64'd6);

        // idle writeHi
        writeHi = 1'b1; writeData = 32'hAAAA0000;
        tick();
        writeHi = 1'b0;
        chk("write_hi", {32'd0, hi}, {32'd0, 32'hAAAA0000});

        // flush with start in IDLE: start dropped
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_idle", {63'd0, busy}, 64'd0);

        // reset mid-operation clears hi/lo
        op = 2'd0; operand1 = 32'd3; operand2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_hi", {32'd0, hi}, 64'd0);
        chk("rst_mid_lo", {32'd0, lo}, 64'd0);
        chk("rst_mid_done", {63'd0, done}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller sitting beside the execution stage ALU. Accepts one multiply or divide operation per request, runs it over WIDTH cycles with a radix-2 shift/add (multiply) or restoring shift/subtract (divide) datapath, and holds the 2·WIDTH result in HI/LO registers. It raises a stall toward the execution stage while a new request or HI/LO read collides with a busy unit, and it aborts on pipeline flush.

## Interface
- WIDTH, 32, operand and HI/LO width (≥ 2)
- clock  input  1  rising-edge clock
- reset  input  1  reset reset, synchronous, active-high; clock clock
- start  input  1  request from execution stage, qualified by non-bubbled instruction
- op  input  2  0 MULTU, 1 MULT, 2 DIVU, 3 DIV
- operand1  input  WIDTH  multiplicand / dividend
- operand2  input  WIDTH  multiplier / divisor
- readHiLo  input  1  execution stage instruction reads HI or LO this cycle
- writeHi, writeLo  input  1  direct HI/LO write (move-to), honoured only when idle
- writeData  input  WIDTH  data for writeHi/writeLo
- flush  input  1  discard in-flight operation
- busy  output  1  state is RUN or FIX
- done  output  1  one-cycle pulse, HI/LO just updated
- stall  output  1  busy && (start || readHiLo || writeHi || writeLo)
- hi, lo  output  WIDTH  result registers (hi = high product / remainder, lo = low product / quotient)

## Operation
- FSM states: IDLE, RUN, FIX. Reset → IDLE; hi=0, lo=0, busy=0, done=0, counter=0.
- IDLE: start=1 latches op, magnitudes of operands (signed ops use |x|, sign flags saved), counter=WIDTH-1 → RUN. Else writeHi/writeLo update hi/lo at the edge.
- RUN: one iteration per cycle; counter decrements; at counter=0 → FIX.
- Multiply: 2·WIDTH accumulator, add-and-shift right per multiplier bit.
- Divide: remainder/quotient shift left, subtract divisor if no borrow, quotient bit = !borrow.
- FIX: apply signs, write hi/lo, → IDLE, done=1 next cycle.
  - MULT: product negated if signs differ (two's complement over 2·WIDTH).
  - DIV: quotient negated if signs differ (truncation toward zero); remainder takes dividend's sign.
  - Divisor zero (DIVU or DIV): hi=operand1 as latched (original value), lo=all ones.
  - DIV of most-negative by −1: lo=most-negative, hi=0 (falls out of algorithm).
- start, writeHi, writeLo while busy: ignored; stall holds the requesting instruction.
- flush any state: → IDLE next edge, hi/lo unchanged, no done pulse. flush with start in IDLE: start ignored.
- reset has priority over flush; reset mid-operation clears hi/lo to 0.
- start and writeHi/writeLo in the same IDLE cycle: start wins, writes dropped.

## Timing
- start accepted in cycle 0 (IDLE) → RUN cycles 1..WIDTH → FIX cycle WIDTH+1 → hi/lo valid and done=1 in cycle WIDTH+2, busy=0 in that cycle.
- Back-to-back: new start may be issued in the done cycle (accepted, no stall).
- stall is combinational from inputs and registered busy; no combinational path from start to busy.
- hi/lo are registers; readHiLo in done cycle sees new values.

## Configuration
- MULDIV_EARLY_OUT_EN defined: for MULTU/MULT, RUN exits to FIX as soon as remaining unshifted multiplier bits are all zero (accumulator pre-aligned by remaining shift in FIX); operand2=0 goes directly to FIX after cycle 1. Divide latency unchanged.
- Undefined: fixed WIDTH+2 latency for all ops.

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF → done at cycle 34: hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1..33.
- MULT −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 → hi=100, lo=0xFFFFFFFF; DIV 0x80000000 / −1 → lo=0x80000000, hi=0.
- Start DIVU 10/3, readHiLo in cycle 5 → stall=1 cycles 5..33, 0 in cycle 34 with hi=1, lo=3.
- Start MULTU, flush in cycle 10 → idle cycle 11, hi/lo retain prior values, no done; writeLo 0x1234 in cycle 12 → lo=0x1234.
- With MULDIV_EARLY_OUT_EN: MULTU 5 × 3 → done before cycle 34, hi=0, lo=15; result identical with macro undefined.
